// File: rtl/aes192_round_key_store.sv
// Purpose: stores the AES-192 round keys (key 0 plus 12 expanded subkeys) and streams them in encrypt or decrypt order.
// Latency: the first key is registered one cycle after stream_start; after that, one key per cycle while rk_ready is held.
// Backpressure: valid/ready handshake; rk_out, rk_idx and rk_last hold while rk_ready is low.
module aes192_round_key_store #(
    parameter int NUM_RK = 13,
    parameter int RK_W   = 128
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [RK_W-1:0] key0_in,
    input  logic [RK_W-1:0] skey_in,
    input  logic            skey_valid,
    input  logic            stream_start,
    input  logic            stream_dir,
    input  logic            rk_ready,
    output logic [RK_W-1:0] rk_out,
    output logic            rk_valid,
    output logic [3:0]      rk_idx,
    output logic            rk_last,
    output logic            keys_ready,
    output logic            busy,
    output logic            err_overrun
);

    localparam logic [3:0] LAST = 4'(NUM_RK - 1);

    typedef enum logic [1:0] {IDLE, LOAD, READY, STREAM} state_t;

    state_t          state, state_nxt;
    logic [3:0]      wp, rp;
    logic            dir;
    logic [RK_W-1:0] slot [NUM_RK];

    logic            wr_en, wr_last, start_go, hs, hs_last;
    logic [3:0]      rp_start, rp_step, rd_idx, end_idx;
    logic [RK_W-1:0] rd_key;

    // load wins over every other request in the same cycle
    always_comb begin
        wr_en    = (state == LOAD) && skey_valid && !load;
        wr_last  = wr_en && (wp == LAST);
        start_go = (state == READY) && stream_start && !load;
        hs       = (state == STREAM) && rk_valid && rk_ready && !load;
        hs_last  = hs && rk_last;
        rp_start = stream_dir ? LAST : 4'd0;
        rp_step  = dir ? (rp - 4'd1) : (rp + 4'd1);
        rd_idx   = start_go ? rp_start : rp_step;
        end_idx  = (start_go ? stream_dir : dir) ? 4'd0 : LAST;
        rd_key   = (rd_idx <= LAST) ? slot[rd_idx] : '0;
    end

    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                LOAD:    if (wr_last)      state_nxt = READY;
                READY:   if (stream_start) state_nxt = STREAM;
                STREAM:  if (hs_last)      state_nxt = READY;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign busy = (state == LOAD) || (state == STREAM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_RK; i++) begin
                slot[i] <= '0;
            end
            wp          <= '0;
            rp          <= '0;
            dir         <= 1'b0;
            rk_out      <= '0;
            rk_valid    <= 1'b0;
            rk_idx      <= '0;
            rk_last     <= 1'b0;
            keys_ready  <= 1'b0;
            err_overrun <= 1'b0;
        end else if (load) begin
            slot[0]     <= key0_in;
            wp          <= 4'd1;
            keys_ready  <= 1'b0;
            err_overrun <= 1'b0;
            rk_valid    <= 1'b0;
            rk_last     <= 1'b0;
        end else begin
            if (skey_valid && (state != LOAD)) begin
                err_overrun <= 1'b1;
            end
            if (wr_en) begin
                slot[wp] <= skey_in;
                wp       <= wp + 4'd1;
                if (wr_last) begin
                    keys_ready <= 1'b1;
                end
            end
            if (start_go) begin
                dir      <= stream_dir;
                rp       <= rp_start;
                rk_out   <= rd_key;
                rk_idx   <= rd_idx;
                rk_last  <= (rd_idx == end_idx);
                rk_valid <= 1'b1;
            end
            // rp parks on the final index, so it never wraps
            if (hs) begin
                if (rk_last) begin
                    rk_valid <= 1'b0;
                end else begin
                    rp      <= rp_step;
                    rk_out  <= rd_key;
                    rk_idx  <= rd_idx;
                    rk_last <= (rd_idx == end_idx);
                end
            end
        end
    end

endmodule
